// File: rtl/carry_lookahead_subtractor_pipe.sv
// Two-stage pipelined carry-lookahead subtractor: o_result = {borrow, i_min - i_sub}.
// The low half is summed in stage 1, the high half in stage 2 from the registered carry.

module carry_lookahead_subtractor_pipe_cla #(
  parameter int N     = 4,
  parameter int GROUP = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);
  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is the flattened sum of products back to its group's carry-in;
  // only group carry-ins chain from one group to the next.
  always_comb begin
    int   base;
    logic pp;
    logic cc;
    // NOTE: every variable written here gets a value before any branch or loop,
    // so no path leaves one holding its old value and no latch is inferred.
    c    = '0;
    base = 0;
    pp   = 1'b1;
    cc   = 1'b0;
    c[0] = cin;
    for (int k = 0; k < N; k++) begin
      base = (k / GROUP) * GROUP;
      pp   = 1'b1;
      cc   = 1'b0;
      for (int j = k; j >= base; j--) begin
        cc = cc | (pp & g[j]);
        pp = pp & p[j];
      end
      c[k+1] = cc | (pp & c[base]);
    end
  end

  assign sum  = p ^ c[N-1:0];
  assign cout = c[N];
endmodule

module carry_lookahead_subtractor_pipe #(
  parameter int WIDTH = 8,
  parameter int GROUP = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_min,
  input  logic [WIDTH-1:0] i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH:0]   o_result
);
  localparam int LO = WIDTH / 2;
  localparam int HI = WIDTH - LO;

  logic [WIDTH-1:0] sub_n;
  logic [LO-1:0]    lo_sum;
  logic             lo_cout;
  logic [HI-1:0]    hi_sum;
  logic             hi_cout;

  logic             s1_valid;
  logic [LO-1:0]    s1_lo_diff;
  logic             s1_carry;
  logic [HI-1:0]    s1_hi_min;
  logic [HI-1:0]    s1_hi_nsub;
  logic             s2_valid;
  logic [WIDTH:0]   s2_result;
  logic             adv1;
  logic             adv2;

  assign sub_n = ~i_sub;

  carry_lookahead_subtractor_pipe_cla #(.N(LO), .GROUP(GROUP)) u_lo (
    .a    (i_min[LO-1:0]),
    .b    (sub_n[LO-1:0]),
    .cin  (1'b1),
    .sum  (lo_sum),
    .cout (lo_cout)
  );

  carry_lookahead_subtractor_pipe_cla #(.N(HI), .GROUP(GROUP)) u_hi (
    .a    (s1_hi_min),
    .b    (s1_hi_nsub),
    .cin  (s1_carry),
    .sum  (hi_sum),
    .cout (hi_cout)
  );

  assign adv2    = !s2_valid || i_ready;
  assign adv1    = !s1_valid || adv2;
  assign o_ready = adv1;

  // NOTE: datapath registers are reset along with the valid flags so o_result
  // reads 0 after reset and nothing unknown ever reaches the output.
  always_ff @(posedge i_clk) begin
    // NOTE: state uses non-blocking assignments so both stages sample the
    // pre-edge values and shift together.
    if (!i_rst_n) begin
      s1_valid   <= 1'b0;
      s1_lo_diff <= '0;
      s1_carry   <= 1'b0;
      s1_hi_min  <= '0;
      s1_hi_nsub <= '0;
    end else if (adv1) begin
      s1_valid <= i_valid;
      if (i_valid) begin
        s1_lo_diff <= lo_sum;
        s1_carry   <= lo_cout;
        s1_hi_min  <= i_min[WIDTH-1:LO];
        s1_hi_nsub <= sub_n[WIDTH-1:LO];
      end
    end
  end

  // Borrow is the inverted carry out of the top bit.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s2_valid  <= 1'b0;
      s2_result <= '0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_result <= {~hi_cout, hi_sum, s1_lo_diff};
      end
    end
  end

  assign o_valid  = s2_valid;
  assign o_result = s2_result;
endmodule

// File: tb/tb_carry_lookahead_subtractor_pipe.sv
// Bench for carry_lookahead_subtractor_pipe: directed vectors on an 8-bit instance,
// exhaustive operands with random backpressure on a 3-bit instance, both scoreboarded.

module tb_carry_lookahead_subtractor_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       v8, rdy8, ready8, ov8;
  logic [7:0] min8, sub8;
  logic [8:0] res8;
  logic       v3, rdy3, ready3, ov3;
  logic [2:0] min3, sub3;
  logic [3:0] res3;

  carry_lookahead_subtractor_pipe #(.WIDTH(8), .GROUP(4)) u8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(v8), .o_ready(ready8),
    .i_min(min8), .i_sub(sub8), .o_valid(ov8), .i_ready(rdy8), .o_result(res8)
  );

  carry_lookahead_subtractor_pipe #(.WIDTH(3), .GROUP(2)) u3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(v3), .o_ready(ready3),
    .i_min(min3), .i_sub(sub3), .o_valid(ov3), .i_ready(rdy3), .o_result(res3)
  );

  typedef struct {
    logic [8:0] res;
    int         acc;
  } entry_t;

  entry_t q8[$];
  entry_t q3[$];
  int     cyc = 0;
  int     n_checks = 0;
  int     n_fail = 0;
  bit     armed = 1'b0;
  bit     rand3_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Golden difference: borrow iff a < b, low bits are (a - b) mod 2**w.
  function automatic logic [8:0] model(input int w, input int a, input int b);
    int diff;
    diff = a - b;
    if (diff < 0) diff = diff + (1 << w);
    return 9'(((a < b) ? (1 << w) : 0) + diff);
  endfunction

  always @(posedge clk) cyc++;

  // Outputs are checked on the falling edge; an entry is visible one edge after
  // its accepting edge once it is the oldest, and two entries fill the pipe.
  always @(negedge clk) begin
    bit ev8, er8, ev3, er3;
    if (armed) begin
      ev8 = (q8.size() > 0) && ((cyc - q8[0].acc) >= 1);
      er8 = !(q8.size() == 2 && !rdy8);
      check("valid8", 32'(ov8), 32'(ev8));
      check("ready8", 32'(ready8), 32'(er8));
      if (ev8) check("result8", 32'(res8), 32'(q8[0].res));
      ev3 = (q3.size() > 0) && ((cyc - q3[0].acc) >= 1);
      er3 = !(q3.size() == 2 && !rdy3);
      check("valid3", 32'(ov3), 32'(ev3));
      check("ready3", 32'(ready3), 32'(er3));
      if (ev3) check("result3", 32'(res3), 32'(q3[0].res));
      if (!rst_n) begin
        q8.delete();
        q3.delete();
      end else begin
        if (ev8 && rdy8) void'(q8.pop_front());
        if (v8 && er8) q8.push_back('{res: model(8, int'(min8), int'(sub8)), acc: cyc + 1});
        if (ev3 && rdy3) void'(q3.pop_front());
        if (v3 && er3) q3.push_back('{res: model(3, int'(min3), int'(sub3)), acc: cyc + 1});
      end
    end
  end

  initial begin
    rdy3 = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rdy3 = rand3_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single pair through an empty pipe with i_ready = 1, checked against a literal.
  task automatic pair_lit(input string name, input logic [7:0] a, input logic [7:0] b,
                          input logic [8:0] exp);
    check({name, " ready"}, 32'(ready8), 32'd1);
    v8 = 1'b1; min8 = a; sub8 = b;
    tick();
    v8 = 1'b0;
    check({name, " early"}, 32'(ov8), 32'd0);
    tick();
    check({name, " valid"}, 32'(ov8), 32'd1);
    check(name, 32'(res8), 32'(exp));
    tick();
  endtask

  task automatic send3(input logic [2:0] a, input logic [2:0] b);
    bit accepted;
    accepted = 1'b0;
    v3 = 1'b1; min3 = a; sub3 = b;
    for (int t = 0; t < 64 && !accepted; t++) begin
      @(negedge clk);
      accepted = ready3;
      tick();
    end
    if (!accepted) check("send3 timeout", 32'd0, 32'd1);
    v3 = 1'b0;
  endtask

  initial begin
    int fail_before;
    rst_n = 1'b0;
    v8 = 1'b0; min8 = '0; sub8 = '0; rdy8 = 1'b1;
    v3 = 1'b0; min3 = '0; sub3 = '0;
    repeat (2) tick();
    armed = 1'b1;
    check("reset valid", 32'(ov8), 32'd0);
    check("reset result", 32'(res8), 32'd0);
    check("reset ready", 32'(ready8), 32'd1);
    rst_n = 1'b1;
    tick();

    pair_lit("200-100", 8'd200, 8'd100, 9'h064);
    pair_lit("0x10-0x01", 8'h10, 8'h01, 9'h00F);
    pair_lit("0x80-0x81", 8'h80, 8'h81, 9'h1FF);
    pair_lit("0-0", 8'h00, 8'h00, 9'h000);
    pair_lit("0-max", 8'h00, 8'hFF, 9'h101);
    pair_lit("max-max", 8'hFF, 8'hFF, 9'h000);

    // Back-to-back pairs emerge on consecutive cycles.
    v8 = 1'b1; min8 = 8'd100; sub8 = 8'd200;
    tick();
    min8 = 8'd0; sub8 = 8'd1;
    tick();
    v8 = 1'b0;
    check("b2b first", 32'(res8), 32'h19C);
    tick();
    check("b2b second valid", 32'(ov8), 32'd1);
    check("b2b second", 32'(res8), 32'h1FF);
    tick();
    check("b2b drained", 32'(ov8), 32'd0);

    // Backpressure: two accepts fill the pipe, the head is held, then drains in order.
    rdy8 = 1'b0;
    v8 = 1'b1; min8 = 8'd5; sub8 = 8'd3;
    tick();
    min8 = 8'd9; sub8 = 8'd9;
    check("bp second ready", 32'(ready8), 32'd1);
    tick();
    min8 = 8'd1; sub8 = 8'd2;
    for (int i = 0; i < 3; i++) begin
      check("bp full ready", 32'(ready8), 32'd0);
      check("bp hold", 32'(res8), 32'h002);
      if (i < 2) tick();
    end
    rdy8 = 1'b1;
    #1;
    check("bp release ready", 32'(ready8), 32'd1);
    tick();
    v8 = 1'b0;
    check("bp out 9-9", 32'(res8), 32'h000);
    tick();
    check("bp out 1-2", 32'(res8), 32'h1FF);
    tick();
    check("bp drained", 32'(ov8), 32'd0);

    // Reset with two pairs in flight discards both.
    rdy8 = 1'b0;
    v8 = 1'b1; min8 = 8'd7; sub8 = 8'd3;
    tick();
    min8 = 8'd8; sub8 = 8'd1;
    tick();
    v8 = 1'b0;
    check("flight head", 32'(res8), 32'h004);
    rst_n = 1'b0;
    tick();
    check("rst valid", 32'(ov8), 32'd0);
    check("rst result", 32'(res8), 32'd0);
    check("rst ready", 32'(ready8), 32'd1);
    rst_n = 1'b1;
    rdy8 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("no stale", 32'(ov8), 32'd0);
    end

    // Narrow instance: every operand pair, ten passes, random downstream ready.
    fail_before = n_fail;
    rand3_en = 1'b1;
    for (int pass = 0; pass < 10; pass++)
      for (int a = 0; a < 8; a++)
        for (int b = 0; b < 8; b++)
          send3(3'(a), 3'(b));
    rand3_en = 1'b0;
    for (int t = 0; t < 20 && q3.size() > 0; t++) tick();
    check("drain3", 32'(q3.size()), 32'd0);
    if (n_fail == fail_before) $display("Test: PASSED");
    else $display("Test: failed with %0d errors", n_fail - fail_before);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
